tmul_tile_mac: RTL

//  Parametrised, time-multiplexed tile multiply-accumulate engine; successor to the fixed 8x8 TMUL array.

---
 rtl/tmul_pkg.sv | 27 ++
 rtl/tmul_mac_lane.sv | 66 ++++++
 rtl/tmul_tile_mac.sv | 133 +++++++++++++
 3 files changed

// File: rtl/tmul_pkg.sv
// Shared types and helpers for the tile multiply-accumulate engine.
// Holds the FSM state enum, default widths, and lane slice helpers.
`timescale 1ns/1ps
package tmul_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int DEF_A_W   = 32;
  localparam int DEF_N     = 8;
  localparam int DEF_K     = 8;
  localparam int DEF_ACC_W = 64;

  // Low bit of lane 'lane' in a flat bus of 'width'-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Counter width able to hold 0..depth-1, never narrower than one bit.
  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tmul_mac_lane.sv
// One column lane: multiplier, product register and accumulator.
// Optional macro TMUL_SAT_EN selects a saturating add with a per-lane
// carry indication; without it the add wraps modulo 2^ACC_W.
`timescale 1ns/1ps
module tmul_mac_lane
  import tmul_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [A_W-1:0]   a,
  input  logic [A_W-1:0]   b,
  input  logic             add_en,
  input  logic             zero_base,
  output logic [ACC_W-1:0] acc
`ifdef TMUL_SAT_EN
  , output logic           sat_hit
`endif
);

  logic [2*A_W-1:0] prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] acc_next;

  // Register the lane product for every accepted beat.
  // NOTE: no reset on prod; it is only consumed when the reset-cleared valid flag is set.
  always_ff @(posedge clk) begin
    if (load) begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      prod <= (2*A_W)'(a) * (2*A_W)'(b);
    end
  end

  assign prod_ext = ACC_W'(prod);
  assign base     = zero_base ? '0 : acc;

`ifdef TMUL_SAT_EN
  logic [ACC_W:0] sum_ext;

  // Saturating add: a carry out of the accumulator clamps to all-ones.
  always_comb begin
    sum_ext  = {1'b0, base} + {1'b0, prod_ext};
    acc_next = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    sat_hit  = add_en & sum_ext[ACC_W];
  end
`else
  // Wrap-around add.
  always_comb begin
    acc_next = base + prod_ext;
  end
`endif

  // Accumulator: cleared by reset, updated one cycle after a product registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/tmul_tile_mac.sv
// Time-multiplexed tile multiply-accumulate engine.
// Streams one A element and one N-lane B row per beat over K beats into
// N column accumulators, then holds the result until it is consumed.
// Optional macro TMUL_SAT_EN enables saturating accumulation and sat_flag.
`timescale 1ns/1ps
module tmul_tile_mac
  import tmul_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int N     = DEF_N,
  parameter int K     = DEF_K,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a_elem,
  input  logic [N*A_W-1:0]   b_row,
  input  logic               acc_keep,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*ACC_W-1:0] c,
  output logic               sat_flag
);

  localparam int KW = cnt_w(K);

  if (ACC_W < 2*A_W) begin : g_bad_acc_w
    $error("tmul_tile_mac: ACC_W must be at least 2*A_W");
  end
  if (K < 1) begin : g_bad_k
    $error("tmul_tile_mac: K must be at least 1");
  end

  state_t        state, state_next;
  logic [KW-1:0] k_cnt;
  logic          beat;
  logic          last_beat;
  logic          prod_valid;
  logic          prod_zero;

  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (k_cnt == KW'(K-1));

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      ST_ACC: begin
        in_ready = 1'b1;
        if (last_beat) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_ACC;
      end
      default: begin
        state_next = ST_ACC;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_ACC;
    else     state <= state_next;
  end

  // Beat counter within the tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_cnt <= '0;
    end else if (beat) begin
      k_cnt <= last_beat ? '0 : k_cnt + 1'b1;
    end
  end

  // Product-stage flags: valid, and whether this product starts from a zero base.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_valid <= 1'b0;
      prod_zero  <= 1'b0;
    end else begin
      prod_valid <= beat;
      prod_zero  <= beat && (k_cnt == '0) && !acc_keep;
    end
  end

`ifdef TMUL_SAT_EN
  logic [N-1:0] lane_sat;
  logic         sat_q;

  // Sticky saturation flag, restarted by the first zero-base accumulate of a tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (prod_valid) begin
      sat_q <= (prod_zero ? 1'b0 : sat_q) | (|lane_sat);
    end
  end

  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

  for (genvar j = 0; j < N; j++) begin : g_lane
    tmul_mac_lane #(
      .A_W   (A_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (beat),
      .a         (a_elem),
      .b         (b_row[lane_lo(j, A_W) +: A_W]),
      .add_en    (prod_valid),
      .zero_base (prod_zero),
      .acc       (c[lane_lo(j, ACC_W) +: ACC_W])
`ifdef TMUL_SAT_EN
      , .sat_hit (lane_sat[j])
`endif
    );
  end

endmodule
